// File: rtl/mru_cache_pkg.sv
// Shared types and width helpers for the MRU cache tag-lookup slice.
// The response struct is sized for the largest supported configuration
// (up to 256 ways, tags up to 64 bits); instances use the low bits.
package mru_cache_pkg;

  localparam int MAX_WAY_W = 8;
  localparam int MAX_TAG_W = 64;

  // Index width for a power-of-two way count (at least one bit).
  function automatic int calc_way_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index width for the set count (at least one bit).
  function automatic int calc_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Age value as seen outside the age array (zero-extended).
  typedef logic [MAX_WAY_W-1:0] age_t;

  typedef struct packed {
    logic                 hit;
    logic [MAX_WAY_W-1:0] way;
    logic                 evict;
    logic [MAX_TAG_W-1:0] evict_tag;
  } lookup_resp_t;

endpackage

// File: rtl/mru_age_update.sv
// Per-set age array. Age 0 is the most recently used way; age N-1 is the
// replacement candidate. Ages within a set are always a permutation of 0..N-1.
module mru_age_update
  import mru_cache_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 32,
  localparam int WAY_W = calc_way_w(N),
  localparam int IDX_W = calc_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WAY_W-1:0] lru_way,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [WAY_W-1:0] upd_way
);

  logic [WAY_W-1:0] ages [DEPTH][N];

  // Reset ages to way index; on access move the way to age 0 and age the younger ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int w = 0; w < N; w++) begin
          ages[s][w] <= WAY_W'(w);
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < N; w++) begin
        if (WAY_W'(w) == upd_way) begin
          ages[upd_idx][w] <= '0;
        end else if (ages[upd_idx][w] < ages[upd_idx][upd_way]) begin
          ages[upd_idx][w] <= ages[upd_idx][w] + 1'b1;
        end
      end
    end
  end

  // Find the oldest way of the read set.
  always_comb begin
    lru_way = '0;
    for (int w = 0; w < N; w++) begin
      if (age_t'(ages[rd_idx][w]) == age_t'(N - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/mru_tag_lookup.sv
// Tag lookup and replacement stage behind the N-way tag memory.
// Optional statistics counters are built only when MRU_STATS_EN is defined.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and a stalled response keeps
// all resp_* fields stable until it transfers.
module mru_tag_lookup
  import mru_cache_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 32,
  parameter int TAG_W = 18,
  localparam int WAY_W = calc_way_w(N),
  localparam int IDX_W = calc_idx_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDX_W-1:0]   req_idx,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_hit,
  output logic [WAY_W-1:0]   resp_way,
  output logic               resp_evict,
  output logic [TAG_W-1:0]   resp_evict_tag,
  output logic [IDX_W-1:0]   mem_rad,
  input  logic [N*TAG_W-1:0] mem_rdat,
  output logic [N-1:0]       mem_we,
  output logic [IDX_W-1:0]   mem_wad,
  output logic [TAG_W-1:0]   mem_wdat,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic [TAG_W-1:0] s1_tag;
  logic [N-1:0]     vbits [DEPTH];

  logic             fwd_valid;
  logic [IDX_W-1:0] fwd_idx;
  logic [WAY_W-1:0] fwd_way;
  logic [TAG_W-1:0] fwd_tag;

  logic             accept;
  logic             fire;
  logic             fire_miss;
  logic [N-1:0]     vset;
  logic [TAG_W-1:0] way_tag [N];
  logic [N-1:0]     match;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] acc_way;
  lookup_resp_t     resp_s;
  logic             unused_resp;

  assign req_ready  = !s1_valid || resp_ready;
  assign accept     = req_valid && req_ready;
  assign resp_valid = s1_valid;
  assign fire       = s1_valid && resp_ready;
  assign fire_miss  = fire && !hit;
  assign mem_rad    = accept ? req_idx : s1_idx;
  assign acc_way    = hit ? hit_way : victim;

  // Pipeline register S1: holds the request while its tags are read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_tag   <= '0;
    end else if (req_ready) begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_idx <= req_idx;
        s1_tag <= req_tag;
      end
    end
  end

  // Valid bits: a firing miss fills the victim way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        vbits[s] <= '0;
      end
    end else if (fire_miss) begin
      vbits[s1_idx][victim] <= 1'b1;
    end
  end

  // One-cycle forward of a fill, hiding the memory's read-old-on-collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_idx   <= '0;
      fwd_way   <= '0;
      fwd_tag   <= '0;
    end else begin
      fwd_valid <= fire_miss;
      if (fire_miss) begin
        fwd_idx <= s1_idx;
        fwd_way <= victim;
        fwd_tag <= s1_tag;
      end
    end
  end

  // Compare all ways, pick the lowest matching way and the lowest invalid way.
  always_comb begin
    vset    = vbits[s1_idx];
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < N; w++) begin
      way_tag[w] = mem_rdat[w*TAG_W +: TAG_W];
      if (fwd_valid && (fwd_idx == s1_idx) && (fwd_way == WAY_W'(w))) begin
        way_tag[w] = fwd_tag;
      end
      match[w] = vset[w] && (way_tag[w] == s1_tag);
    end
    for (int w = N - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!vset[w]) inv_way = WAY_W'(w);
    end
    hit    = |match;
    victim = (&vset) ? lru_way : inv_way;
  end

  // Assemble the response and the fill write.
  always_comb begin
    resp_s           = '0;
    resp_s.hit       = hit;
    resp_s.way       = MAX_WAY_W'(acc_way);
    resp_s.evict     = !hit && vset[victim];
    resp_s.evict_tag = MAX_TAG_W'(way_tag[victim]);
    mem_we           = '0;
    if (fire_miss) begin
      mem_we[victim] = 1'b1;
    end
  end

  assign resp_hit       = resp_s.hit;
  assign resp_way       = resp_s.way[WAY_W-1:0];
  assign resp_evict     = resp_s.evict;
  assign resp_evict_tag = resp_s.evict_tag[TAG_W-1:0];
  assign mem_wad        = s1_idx;
  assign mem_wdat       = s1_tag;
  // Upper struct bits beyond this configuration's widths are padding.
  assign unused_resp    = ^resp_s;

  mru_age_update #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (s1_idx),
    .lru_way (lru_way),
    .upd_en  (fire),
    .upd_idx (s1_idx),
    .upd_way (acc_way)
  );

`ifdef MRU_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Count fired hits and misses; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (fire) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_mru_tag_lookup.sv
// Bench for mru_tag_lookup: tag memory model, recency-list reference model,
// expected-response queue and a negedge monitor.
module tb_mru_tag_lookup;

  localparam int N     = 4;
  localparam int DEPTH = 32;
  localparam int TAG_W = 18;
  localparam int IDX_W = 5;
  localparam int WAY_W = 2;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             evict;
    logic [TAG_W-1:0] etag;
    logic [N-1:0]     we;
    logic [IDX_W-1:0] wad;
    logic [TAG_W-1:0] wdat;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               req_valid, req_ready;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               resp_valid, resp_ready;
  logic               resp_hit;
  logic [WAY_W-1:0]   resp_way;
  logic               resp_evict;
  logic [TAG_W-1:0]   resp_evict_tag;
  logic [IDX_W-1:0]   mem_rad;
  logic [N*TAG_W-1:0] mem_rdat;
  logic [N-1:0]       mem_we;
  logic [IDX_W-1:0]   mem_wad;
  logic [TAG_W-1:0]   mem_wdat;
  logic [31:0]        hit_cnt, miss_cnt;

  mru_tag_lookup #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_idx        (req_idx),
    .req_tag        (req_tag),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_evict     (resp_evict),
    .resp_evict_tag (resp_evict_tag),
    .mem_rad        (mem_rad),
    .mem_rdat       (mem_rdat),
    .mem_we         (mem_we),
    .mem_wad        (mem_wad),
    .mem_wdat       (mem_wdat),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  // ---------------- tag memory model (registered read, read-old) ----------------
  logic [TAG_W-1:0] mem [DEPTH][N];
  initial begin
    for (int s = 0; s < DEPTH; s++)
      for (int w = 0; w < N; w++)
        mem[s][w] = TAG_W'($urandom);
    mem_rdat = '0;
  end
  always @(posedge clk) begin
    for (int w = 0; w < N; w++) begin
      mem_rdat[w*TAG_W +: TAG_W] <= mem[mem_rad][w];
      if (mem_we[w]) mem[mem_wad][w] <= mem_wdat;
    end
  end

  // ---------------- reference model ----------------
  // m_list[s] is the set's recency order: element 0 most recent, last = replacement.
  bit               m_valid [DEPTH][N];
  logic [TAG_W-1:0] m_tag   [DEPTH][N];
  int               m_list  [DEPTH][N];

  task automatic model_reset();
    for (int s = 0; s < DEPTH; s++)
      for (int w = 0; w < N; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_list[s][w]  = w;
      end
  endtask

  task automatic model_access(input int idx, input logic [TAG_W-1:0] tag, output exp_t e);
    int way;
    bit hit;
    bit found_inv;
    int q[$];
    hit = 0; way = 0; found_inv = 0;
    for (int w = 0; w < N; w++)
      if (!hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
        hit = 1; way = w;
      end
    if (!hit) begin
      for (int w = 0; w < N; w++)
        if (!found_inv && !m_valid[idx][w]) begin
          found_inv = 1; way = w;
        end
      if (!found_inv) way = m_list[idx][N-1];
    end
    e = '0;
    e.hit  = hit;
    e.way  = WAY_W'(way);
    e.wad  = IDX_W'(idx);
    e.wdat = tag;
    if (!hit) begin
      e.evict = m_valid[idx][way];
      e.etag  = m_tag[idx][way];
      e.we[way] = 1'b1;
      m_valid[idx][way] = 1'b1;
      m_tag[idx][way]   = tag;
    end
    for (int k = 0; k < N; k++) q.push_back(m_list[idx][k]);
    for (int k = 0; k < q.size(); k++)
      if (q[k] == way) begin
        q.delete(k);
        break;
      end
    q.push_front(way);
    for (int k = 0; k < N; k++) m_list[idx][k] = q[k];
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int fired_hits = 0;
  int fired_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare presented responses; pop on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'(0));
      end else begin
        e = exp_t'(exp_q[0]);
        chk("resp_hit", 64'(resp_hit), 64'(e.hit));
        chk("resp_way", 64'(resp_way), 64'(e.way));
        if (!e.hit) begin
          chk("resp_evict", 64'(resp_evict), 64'(e.evict));
          if (e.evict) chk("resp_evict_tag", 64'(resp_evict_tag), 64'(e.etag));
        end
        if (resp_ready) begin
          chk("mem_we", 64'(mem_we), 64'(e.we));
          if (!e.hit) begin
            chk("mem_wad", 64'(mem_wad), 64'(e.wad));
            chk("mem_wdat", 64'(mem_wdat), 64'(e.wdat));
            fired_misses++;
          end else begin
            fired_hits++;
          end
          void'(exp_q.pop_front());
        end else begin
          chk("mem_we_stall", 64'(mem_we), 64'(0));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int idx, input logic [TAG_W-1:0] tag,
                       input bit rr, output bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid  = v;
    req_idx    = IDX_W'(idx);
    req_tag    = tag;
    resp_ready = rr;
    #1;
    acc = v && req_ready;
    if (acc) begin
      model_access(idx, tag, e);
      exp_q.push_back(EXP_W'(e));
    end
  endtask

  task automatic send(input int idx, input logic [TAG_W-1:0] tag);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      drive(1'b1, idx, tag, 1'b1, acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic idle();
    bit acc;
    drive(1'b0, 0, '0, 1'b1, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    bit pend;
    bit v;
    bit rr;
    int idx;
    int n;
    logic [TAG_W-1:0] tag;

    rst = 1'b1;
    req_valid = 1'b0;
    req_idx = '0;
    req_tag = '0;
    resp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    chk("rst_miss_cnt", 64'(miss_cnt), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // First miss, then same request back-to-back (needs forwarding).
    send(3, 18'h11);
    send(3, 18'h11);
    chk("first_miss_hit", 64'(resp_hit), 64'(0));
    chk("first_miss_we", 64'(mem_we), 64'(4'b0001));
    chk("first_miss_wad", 64'(mem_wad), 64'(3));
    idle();
    chk("fwd_hit", 64'(resp_hit), 64'(1));
    chk("fwd_way", 64'(resp_way), 64'(0));
    chk("fwd_we", 64'(mem_we), 64'(0));

    // Fill set 5, touch A, then E must evict B.
    send(5, 18'h0A);
    send(5, 18'h0B);
    send(5, 18'h0C);
    send(5, 18'h0D);
    send(5, 18'h0A);
    send(5, 18'h0E);
    idle();
    chk("evict_hit", 64'(resp_hit), 64'(0));
    chk("evict_way", 64'(resp_way), 64'(1));
    chk("evict_flag", 64'(resp_evict), 64'(1));
    chk("evict_tag", 64'(resp_evict_tag), 64'(18'h0B));

    // Backpressure for three cycles with a request waiting.
    send(7, 18'h77);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7, 18'h88, 1'b0, acc);
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    send(7, 18'h88);
    idle();
    idle();

    // Reset with S1 occupied; the pending response is discarded.
    send(3, 18'h11);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    fired_hits = 0;
    fired_misses = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    send(3, 18'h11);
    idle();
    chk("post_rst_hit", 64'(resp_hit), 64'(0));
    chk("post_rst_way", 64'(resp_way), 64'(0));
    chk("post_rst_evict", 64'(resp_evict), 64'(0));

    // Random traffic over a few sets and a small tag pool.
    pend = 0;
    v = 0;
    idx = 0;
    tag = '0;
    for (int i = 0; i < 800; i++) begin
      if (!pend) begin
        v   = ($urandom_range(0, 3) != 0);
        idx = $urandom_range(10, 13);
        tag = TAG_W'($urandom_range(0, 7) + 'h200);
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(v, idx, tag, rr, acc);
      pend = v && !acc;
    end

    // Drain.
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
`ifdef MRU_STATS_EN
    chk("hit_cnt", 64'(hit_cnt), 64'(fired_hits));
    chk("miss_cnt", 64'(miss_cnt), 64'(fired_misses));
`else
    chk("hit_cnt_off", 64'(hit_cnt), 64'(0));
    chk("miss_cnt_off", 64'(miss_cnt), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mru_tag_lookup.md
# mru_tag_lookup

Tag-lookup and replacement stage of the MRU cache, sitting directly downstream of the N-way dual-ported tag memory (`nway_dp_bram`). It accepts (set index, tag) requests, drives the memory read address, and compares the N returned way tags against the request. It reports hit/way or a victim way, and on a miss writes the new tag into the victim way. Valid bits and per-set MRU ages live in flops inside this block; the memory holds tags only.

## Interface
Parameters:
- `N`, 4: number of ways, power of two ≥2; `WAY_W = $clog2(N)`
- `DEPTH`, 32: number of sets; `IDX_W = $clog2(DEPTH)`
- `TAG_W`, 18: tag width, equal to the memory `WIDTH`

Ports:
- `clk` in 1: the single clock
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1, `req_ready` out 1: request handshake
- `req_idx` in IDX_W, `req_tag` in TAG_W: request set and tag
- `resp_valid` out 1, `resp_ready` in 1: response handshake
- `resp_hit` out 1: tag matched a valid way
- `resp_way` out WAY_W: hit way, or victim way on a miss
- `resp_evict` out 1: the miss replaced a valid line
- `resp_evict_tag` out TAG_W: tag of the replaced line, valid when `resp_evict` is high
- `mem_rad` out IDX_W: memory read address
- `mem_rdat` in N*TAG_W: way i at `[i*TAG_W +: TAG_W]`, one cycle after `mem_rad`
- `mem_we` out N, `mem_wad` out IDX_W, `mem_wdat` out TAG_W: memory write port
- `hit_cnt` out 32, `miss_cnt` out 32: statistics (see Configuration)

## Operation
- One pipeline register, S1, holds `s1_valid`, `s1_idx` and `s1_tag`.
- `req_ready = !s1_valid || resp_ready`. A request is accepted when `req_valid && req_ready`.
- `mem_rad = accept ? req_idx : s1_idx`. While stalled, the memory re-reads the S1 set every cycle.
- Compare: way w matches if `valid[s1_idx][w]` is set and its tag equals `s1_tag`.
  - The tag is `mem_rdat` way w, or the forwarded tag (see below).
  - If more than one way matches, the lowest index wins.
- Miss victim: the lowest-index invalid way; if all ways are valid, the way with `age == N-1`.
- Fire (`resp_valid && resp_ready`):
  - On a miss: `mem_we` = one-hot victim, `mem_wad = s1_idx`, `mem_wdat = s1_tag`, and the victim's valid bit is set.
  - On hit or miss, the accessed way w gets age 0. Every way in the set with `age < age[w]` increments.
- `mem_we` is 0 whenever there is no firing miss.
- Forwarding: a firing miss registers (idx, way, tag) with a 1-cycle valid flag. The next compare uses the forwarded tag for that way when idx equals `s1_idx`. This covers the memory's read-old behaviour when it reads and writes the same address in the same cycle.
- `resp_evict` = miss and the victim was valid; `resp_evict_tag` = victim's `mem_rdat` or forwarded tag.
- Reset state:
  - `s1_valid = 0`, all valid bits 0, forward flag 0.
  - Set ages: way i = i.
  - Counters 0, `resp_valid = 0`, `req_ready = 1`, `mem_we = 0`.
- Reset mid-operation discards the S1 request with no response. Memory contents are ignored, because all valid bits are clear.

## Timing
- Request accepted at cycle t; `resp_valid` rises at t+1. `resp_*` data is combinational from `mem_rdat` and the flops.
- Throughput is one lookup per cycle while `resp_ready` is high.
- Back-to-back requests to the same set after a miss see the new tag at t+1 via forwarding.
- Under backpressure, `resp_*` stays stable and `req_ready` stays low until fire.
- Age and valid updates take effect at the fire edge and are visible to the next compare.

## Configuration
- `MRU_STATS_EN` defined:
  - `hit_cnt` increments on each firing hit; `miss_cnt` on each firing miss.
  - Both are 32-bit, wrap at 2^32, and clear on `rst`.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `mru_cache_pkg` holds:
  - the `IDX_W`/`WAY_W` derivation functions;
  - the `age_t` typedef;
  - a `lookup_resp_t` struct (hit, way, evict, evict_tag).
- Sub-module `mru_age_update`: per-set age flop array with reset init, the accessed-way update rule, and the LRU-way output for a read index.

## Test plan
- After reset, N=4: req (idx 3, tag 0x11) → t+1 miss, way 0, `resp_evict = 0`, `mem_we = 4'b0001`, `mem_wad = 3`, `mem_wdat = 0x11`.
- Same request back-to-back, next cycle → hit, way 0, `mem_we = 0`. Passes only if forwarding works.
- Fill set 5 with tags A, B, C, D; access A; then miss with E → victim is B's way, `resp_evict = 1`, `resp_evict_tag = B`.
- Hold `resp_ready = 0` for 3 cycles with `req_valid` high → `req_ready = 0`, `resp_*` stable, a single fire, no dropped or duplicated request.
- Assert `rst` while S1 is valid, then re-request the same idx/tag → miss, victim way 0.
- With `MRU_STATS_EN`: 3 hits and 2 misses fired → `hit_cnt = 3`, `miss_cnt = 2`. Without it: both 0.
